// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: EX/MEM control bit layout, field widths,
// and the occupancy encoding used by the elastic stage registers.
package pipe_pkg;

    localparam int CTRL_REGWRITE    = 0;
    localparam int CTRL_MEMREAD     = 1;
    localparam int CTRL_MEMWRITE    = 2;
    localparam int CTRL_MEMTOREG_LO = 3;

    localparam int ADDR_W = 32;
    localparam int REG_W  = 5;

    localparam int EXMEM_CTRL_W = CTRL_MEMTOREG_LO + 2;
    // ALUOut, RFReadData2, RegWriteAddr, rt, PC
    localparam int EXMEM_DATA_W = ADDR_W + ADDR_W + REG_W + REG_W + ADDR_W;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

endpackage

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline-stage register with a main + skid slot; in_ready and
// out_valid come straight from flops so no ready path crosses the stage.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W            = EXMEM_CTRL_W,
    parameter int DATA_W            = EXMEM_DATA_W,
    parameter bit FLUSH_CLEARS_DATA = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    occ_e state_q, state_d;

    logic              ready_q;
    logic              valid_q;
    logic [CTRL_W-1:0] m_ctrl_q, s_ctrl_q;
    logic [DATA_W-1:0] m_data_q, s_data_q;

    logic in_fire, out_fire;
    logic load_m, m_from_s, load_s;

    assign in_fire  = in_valid & ready_q;
    assign out_fire = valid_q & out_ready;

    always_comb begin
        state_d  = state_q;
        load_m   = 1'b0;
        m_from_s = 1'b0;
        load_s   = 1'b0;
        if (flush) begin
            state_d = OCC_EMPTY;
        end else begin
            unique case (state_q)
                OCC_EMPTY: begin
                    if (in_fire) begin
                        load_m  = 1'b1;
                        state_d = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (in_fire && out_fire) begin
                        load_m = 1'b1;
                    end else if (in_fire) begin
                        load_s  = 1'b1;
                        state_d = OCC_FULL;
                    end else if (out_fire) begin
                        state_d = OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    // ready_q is low here, so only the drain side can move
                    if (out_fire) begin
                        m_from_s = 1'b1;
                        state_d  = OCC_ONE;
                    end
                end
                default: state_d = OCC_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= OCC_EMPTY;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != OCC_FULL);
            valid_q <= (state_d != OCC_EMPTY);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ctrl_q <= '0;
            m_data_q <= '0;
        end else if (flush) begin
            m_ctrl_q <= '0;
            if (FLUSH_CLEARS_DATA) m_data_q <= '0;
        end else if (load_m) begin
            m_ctrl_q <= in_ctrl;
            m_data_q <= in_data;
        end else if (m_from_s) begin
            m_ctrl_q <= s_ctrl_q;
            m_data_q <= s_data_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_ctrl_q <= '0;
            s_data_q <= '0;
        end else if (flush) begin
            s_ctrl_q <= '0;
            if (FLUSH_CLEARS_DATA) s_data_q <= '0;
        end else if (load_s) begin
            s_ctrl_q <= in_ctrl;
            s_data_q <= in_data;
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = valid_q;
    assign out_ctrl  = valid_q ? m_ctrl_q : '0;
    assign out_data  = m_data_q;
    assign occupancy = state_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed scenarios plus a random stream
// checked against a queue-based reference of the elastic stage.
module tb_pipe_skid_reg;
    import pipe_pkg::*;

    localparam int CW = EXMEM_CTRL_W;
    localparam int DW = EXMEM_DATA_W;

    typedef logic [CW+DW-1:0] beat_t;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, out_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;

    logic          in_ready0, out_valid0, in_ready1, out_valid1;
    logic [CW-1:0] out_ctrl0, out_ctrl1;
    logic [DW-1:0] out_data0, out_data1;
    logic [1:0]    occ0, occ1;

    int n_vec = 0;
    int n_err = 0;

    beat_t mq[$];

    always #5 clk = ~clk;

    pipe_skid_reg #(.FLUSH_CLEARS_DATA(1'b0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready0),
        .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid0), .out_ready(out_ready),
        .out_ctrl(out_ctrl0), .out_data(out_data0),
        .occupancy(occ0)
    );

    pipe_skid_reg #(.FLUSH_CLEARS_DATA(1'b1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1),
        .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready),
        .out_ctrl(out_ctrl1), .out_data(out_data1),
        .occupancy(occ1)
    );

    // Reference: a FIFO of at most two beats; accept only when not full.
    task automatic tick();
        bit fi, fo;
        @(posedge clk);
        if (rst || flush) begin
            mq.delete();
        end else begin
            fi = in_valid && (mq.size() < 2);
            fo = out_ready && (mq.size() > 0);
            if (fo) void'(mq.pop_front());
            if (fi) mq.push_back({in_ctrl, in_data});
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ctrl = '0; in_data = '0;
        mq.delete();
        #12;
        n_vec++;
        if (occ0 !== 2'd0) begin
            n_err++; $display("FAIL reset_occ: got %0d want 0", occ0);
        end
        n_vec++;
        if (out_valid0 !== 1'b0) begin
            n_err++; $display("FAIL reset_valid: got %b want 0", out_valid0);
        end
        n_vec++;
        if (out_ctrl0 !== '0) begin
            n_err++; $display("FAIL reset_ctrl: got %h want 0", out_ctrl0);
        end
        n_vec++;
        if (out_data0 !== '0) begin
            n_err++; $display("FAIL reset_data: got %h want 0", out_data0);
        end
        n_vec++;
        if (in_ready0 !== 1'b1) begin
            n_err++; $display("FAIL reset_ready: got %b want 1", in_ready0);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_stream();
        in_ctrl = 5'b00111;
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1;
            in_data = DW'(i);
            tick();
            n_vec++;
            if (out_valid0 !== 1'b1 || out_data0 !== DW'(i)) begin
                n_err++;
                $display("FAIL stream_beat%0d: got v=%b d=%h want v=1 d=%h",
                         i, out_valid0, out_data0, DW'(i));
            end
            n_vec++;
            if (in_ready0 !== 1'b1 || occ0 !== 2'd1 || out_ctrl0 !== 5'b00111) begin
                n_err++;
                $display("FAIL stream_state%0d: got rdy=%b occ=%0d c=%b want 1 1 00111",
                         i, in_ready0, occ0, out_ctrl0);
            end
        end
        in_valid = 1'b0;
        tick();
        n_vec++;
        if (occ0 !== 2'd0 || out_valid0 !== 1'b0 || out_ctrl0 !== '0) begin
            n_err++;
            $display("FAIL stream_drain: got occ=%0d v=%b c=%b want 0 0 0",
                     occ0, out_valid0, out_ctrl0);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        in_ctrl = 5'b00101;
        in_valid = 1'b1;
        in_data = DW'(32'h10);
        tick();
        in_data = DW'(32'h20);
        tick();
        n_vec++;
        if (occ0 !== 2'd2 || in_ready0 !== 1'b0) begin
            n_err++;
            $display("FAIL bp_full: got occ=%0d rdy=%b want 2 0", occ0, in_ready0);
        end
        in_data = DW'(32'h30);
        tick();
        n_vec++;
        if (occ0 !== 2'd2 || out_data0 !== DW'(32'h10)) begin
            n_err++;
            $display("FAIL bp_hold: got occ=%0d d=%h want 2 10", occ0, out_data0);
        end
        out_ready = 1'b1;
        tick();
        n_vec++;
        if (out_data0 !== DW'(32'h20) || occ0 !== 2'd1 || in_ready0 !== 1'b1) begin
            n_err++;
            $display("FAIL bp_second: got d=%h occ=%0d rdy=%b want 20 1 1",
                     out_data0, occ0, in_ready0);
        end
        tick();
        n_vec++;
        if (out_data0 !== DW'(32'h30) || out_valid0 !== 1'b1 || occ0 !== 2'd1) begin
            n_err++;
            $display("FAIL bp_third: got d=%h v=%b occ=%0d want 30 1 1",
                     out_data0, out_valid0, occ0);
        end
        in_valid = 1'b0;
        tick();
        n_vec++;
        if (out_valid0 !== 1'b0 || occ0 !== 2'd0) begin
            n_err++;
            $display("FAIL bp_drain: got v=%b occ=%0d want 0 0", out_valid0, occ0);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_ctrl = 5'b00101;
        in_valid = 1'b1;
        in_data = DW'(32'h01);
        tick();
        in_data = DW'(32'h02);
        tick();
        flush = 1'b1;
        in_data = DW'(32'h40);
        tick();
        flush = 1'b0;
        n_vec++;
        if (occ0 !== 2'd0 || out_valid0 !== 1'b0 || out_ctrl0 !== '0 || in_ready0 !== 1'b1) begin
            n_err++;
            $display("FAIL flush_full: got occ=%0d v=%b c=%b rdy=%b want 0 0 0 1",
                     occ0, out_valid0, out_ctrl0, in_ready0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if (out_valid0 !== 1'b0) begin
                n_err++;
                $display("FAIL flush_ghost%0d: got v=%b d=%h want v=0", i, out_valid0, out_data0);
            end
        end
    endtask

    task automatic test_flush_data();
        out_ready = 1'b0;
        in_ctrl = 5'b00111;
        in_valid = 1'b1;
        in_data = DW'(32'hABC);
        tick();
        in_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_vec++;
        if (out_data0 !== DW'(32'hABC) || out_ctrl0 !== '0) begin
            n_err++;
            $display("FAIL flush_keep_data: got d=%h c=%b want abc 0", out_data0, out_ctrl0);
        end
        n_vec++;
        if (out_data1 !== '0 || out_ctrl1 !== '0 || out_valid1 !== 1'b0) begin
            n_err++;
            $display("FAIL flush_clear_data: got d=%h c=%b v=%b want 0 0 0",
                     out_data1, out_ctrl1, out_valid1);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_ctrl = 5'b00001;
        in_valid = 1'b1;
        in_data = DW'(32'h61);
        tick();
        in_data = DW'(32'h62);
        tick();
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if (occ0 !== 2'd0 || out_valid0 !== 1'b0 || out_ctrl0 !== '0
            || out_data0 !== '0 || in_ready0 !== 1'b1) begin
            n_err++;
            $display("FAIL async_rst: got occ=%0d v=%b c=%b d=%h rdy=%b want 0 0 0 0 1",
                     occ0, out_valid0, out_ctrl0, out_data0, in_ready0);
        end
        mq.delete();
        #1;
        rst = 1'b0;
        in_valid = 1'b1;
        in_data = DW'(32'h55);
        out_ready = 1'b1;
        tick();
        n_vec++;
        if (out_valid0 !== 1'b1 || out_data0 !== DW'(32'h55) || out_ctrl0 !== 5'b00001) begin
            n_err++;
            $display("FAIL rst_recover: got v=%b d=%h c=%b want 1 55 00001",
                     out_valid0, out_data0, out_ctrl0);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic r1, r2;
        beat_t h;
        int bad = 0;
        for (int i = 0; i < 10000; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_ctrl = CW'($urandom());
            in_data = DW'({$urandom(), $urandom(), $urandom(), $urandom()});
            #1;
            r1 = in_ready0;
            out_ready = ~out_ready;
            #1;
            r2 = in_ready0;
            out_ready = ~out_ready;
            n_vec++;
            if (r1 !== r2) begin
                n_err++;
                $display("FAIL rnd_ready_comb%0d: got %b then %b want equal", i, r1, r2);
            end
            tick();
            n_vec++;
            if (occ0 !== 2'(mq.size()) || in_ready0 !== (mq.size() < 2)
                || out_valid0 !== (mq.size() > 0)) begin
                n_err++;
                if (bad++ < 10)
                    $display("FAIL rnd_state%0d: got occ=%0d rdy=%b v=%b want occ=%0d",
                             i, occ0, in_ready0, out_valid0, mq.size());
            end
            if (mq.size() > 0) begin
                h = mq[0];
                n_vec++;
                if ({out_ctrl0, out_data0} !== h) begin
                    n_err++;
                    if (bad++ < 10)
                        $display("FAIL rnd_head%0d: got %h want %h", i,
                                 {out_ctrl0, out_data0}, h);
                end
            end else begin
                n_vec++;
                if (out_ctrl0 !== '0) begin
                    n_err++;
                    if (bad++ < 10)
                        $display("FAIL rnd_bubble%0d: got c=%b want 0", i, out_ctrl0);
                end
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_back_to_back();
        test_flush();
        test_flush_data();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
